// File: rtl/pack_interleave_pkg.sv
// Shared definitions for the two-channel packet interleaver: state encoding and default widths.
package pack_interleave_pkg;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefCntW  = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSend1 = 2'd1,
      StSend2 = 2'd2
   } pi_state_e;

endpackage

// File: rtl/pi_stat_cnt.sv
// Packet / mismatch statistics: packet count wraps, error count saturates at all-ones.
module pi_stat_cnt
   import pack_interleave_pkg::*;
#(
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pkt_inc_i,
   input  logic             err_inc_i,
   output logic [CNT_W-1:0] pkt_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic [CNT_W-1:0] err_q, err_d;

   always_comb begin
      pkt_d = pkt_q;
      err_d = err_q;
      if (pkt_inc_i) begin
         pkt_d = pkt_q + CNT_W'(1);
      end
      if (err_inc_i && (err_q != '1)) begin
         err_d = err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pkt_q <= '0;
         err_q <= '0;
      end else begin
         pkt_q <= pkt_d;
         err_q <= err_d;
      end
   end

   assign pkt_cnt_o = pkt_q;
   assign err_cnt_o = err_q;

endmodule

// File: rtl/pack_interleave.sv
// Merges two time-aligned packet streams into one ch1/ch2 interleaved stream with
// registered outputs, last-marker mismatch detection and packet statistics.
module pack_interleave
   import pack_interleave_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned CNT_W  = DefCntW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data1,
   input  logic              in_valid1,
   input  logic              in_last1,
   output logic              in_ready1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic              in_valid2,
   input  logic              in_last2,
   output logic              in_ready2,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              out_src,
   input  logic              out_ready,
   output logic              len_err,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   pi_state_e state_q, state_d;

   // The ch1 byte goes straight into the output register, so only ch2's byte is held here.
   logic [DATA_W-1:0] d2_q;
   logic              l1_q, l2_q;

   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              out_src_q, out_src_d;
   logic              len_err_q;

   logic load;
   logic mismatch;
   logic pkt_inc;

   assign load = in_valid1 & in_valid2 &
                 ((state_q == StIdle) | ((state_q == StSend2) & out_ready));
   assign mismatch = in_last1 ^ in_last2;

   // Ready is gated by reset so the handshake stays quiet while reset is held.
   assign in_ready1 = load & rst;
   assign in_ready2 = load & rst;

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               state_d     = StSend1;
               out_valid_d = 1'b1;
               out_data_d  = in_data1;
               out_src_d   = 1'b0;
               out_last_d  = 1'b0;
            end
         end
         StSend1: begin
            if (out_ready) begin
               state_d    = StSend2;
               out_data_d = d2_q;
               out_src_d  = 1'b1;
               out_last_d = l1_q | l2_q;
            end
         end
         StSend2: begin
            if (out_ready) begin
               if (load) begin
                  state_d    = StSend1;
                  out_data_d = in_data1;
                  out_src_d  = 1'b0;
                  out_last_d = 1'b0;
               end else begin
                  state_d     = StIdle;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_src_d   = 1'b0;
                  out_last_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_src_d   = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         d2_q        <= '0;
         l1_q        <= 1'b0;
         l2_q        <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_src_q   <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
         len_err_q   <= load & mismatch;
         if (load) begin
            d2_q <= in_data2;
            l1_q <= in_last1;
            l2_q <= in_last2;
         end
      end
   end

   assign pkt_inc = out_valid_q & out_ready & out_last_q;

   pi_stat_cnt #(
      .CNT_W(CNT_W)
   ) u_stat_cnt (
      .clk_i    (clk),
      .rst_ni   (rst),
      .pkt_inc_i(pkt_inc),
      .err_inc_i(load & mismatch),
      .pkt_cnt_o(pkt_cnt),
      .err_cnt_o(err_cnt)
   );

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_pack_interleave.sv
// Directed and randomized checks of pack_interleave against a pair-list reference model.
module tb_pack_interleave;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] in_data1 = '0, in_data2 = '0;
   logic          in_valid1 = 1'b0, in_valid2 = 1'b0;
   logic          in_last1 = 1'b0, in_last2 = 1'b0;
   logic          in_ready1, in_ready2;
   logic [DW-1:0] out_data;
   logic          out_valid, out_last, out_src;
   logic          out_ready = 1'b0;
   logic          len_err;
   logic [CW-1:0] pkt_cnt, err_cnt;

   always #5 clk = ~clk;

   pack_interleave #(
      .DATA_W(DW),
      .CNT_W (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data1 (in_data1),
      .in_valid1(in_valid1),
      .in_last1 (in_last1),
      .in_ready1(in_ready1),
      .in_data2 (in_data2),
      .in_valid2(in_valid2),
      .in_last2 (in_last2),
      .in_ready2(in_ready2),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_src  (out_src),
      .out_ready(out_ready),
      .len_err  (len_err),
      .pkt_cnt  (pkt_cnt),
      .err_cnt  (err_cnt)
   );

   int total = 0;
   int bad   = 0;
   int tcyc  = 0;

   always @(posedge clk) tcyc <= tcyc + 1;

   // Output monitor: captured beats {last, src, data} and protocol statistics.
   logic [9:0] got_q[$];
   int         stall_bad, lone_bad, lenerr_n, first_hs, last_hs, first_out;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_beat  = '0;

   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!out_valid || {out_last, out_src, out_data} !== prev_beat))
            stall_bad++;
         if (out_valid && !out_ready && (in_ready1 || in_ready2)) stall_bad++;
         if (len_err) lenerr_n++;
         if (out_valid && first_out < 0) first_out = tcyc;
         if (out_valid && out_ready) begin
            got_q.push_back({out_last, out_src, out_data});
            if (first_hs < 0) first_hs = tcyc;
            last_hs = tcyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_beat  = {out_last, out_src, out_data};
      end
   end

   // Stimulus description for one run.
   logic [DW-1:0] s_d1[$], s_d2[$];
   logic          s_l1[$], s_l2[$];
   int            start2, rdy_mode, vmode, abort_at, first_load, run_start;
   bit            timed_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, {10'd0, in_ready1, in_ready2, out_valid, out_last, out_src, len_err,
                  out_data, pkt_cnt, err_cnt}, 32'd0);
   endtask

   task automatic clear_run();
      got_q.delete();
      s_d1.delete(); s_d2.delete(); s_l1.delete(); s_l2.delete();
      stall_bad = 0; lone_bad = 0; lenerr_n = 0;
      first_hs = -1; last_hs = -1; first_out = -1; first_load = -1;
      start2 = 0; rdy_mode = 0; vmode = 0; abort_at = 0; timed_out = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle(tag);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic add1(input logic [DW-1:0] d, input logic l);
      s_d1.push_back(d); s_l1.push_back(l);
   endtask

   task automatic add2(input logic [DW-1:0] d, input logic l);
      s_d2.push_back(d); s_l2.push_back(l);
   endtask

   task automatic run_stream();
      int  i1 = 0, i2 = 0, cyc = 0, drain = 0, nexp;
      bit  acc1 = 0, acc2 = 0, v1, v2;
      nexp = 2 * ((s_d1.size() < s_d2.size()) ? s_d1.size() : s_d2.size());
      run_start = tcyc;
      while (drain < 4) begin
         if (abort_at > 0 && got_q.size() >= abort_at - 1 && out_valid) return;
         if (cyc >= 4000) begin
            timed_out = 1'b1;
            break;
         end
         if (got_q.size() >= nexp) drain++;
         v1 = (i1 < s_d1.size()) &&
              (vmode == 0 || (in_valid1 && !acc1) || $urandom_range(0, 1) == 0);
         v2 = (i2 < s_d2.size()) && (cyc >= start2) &&
              (vmode == 0 || (in_valid2 && !acc2) || $urandom_range(0, 1) == 0);
         in_valid1 = v1;
         in_data1  = v1 ? s_d1[i1] : '0;
         in_last1  = v1 ? s_l1[i1] : 1'b0;
         in_valid2 = v2;
         in_data2  = v2 ? s_d2[i2] : '0;
         in_last2  = v2 ? s_l2[i2] : 1'b0;
         if (drain > 0 || rdy_mode == 0) out_ready = 1'b1;
         else if (rdy_mode == 1)         out_ready = (cyc % 2 == 0);
         else                            out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         if ((in_ready1 !== in_ready2) || (in_ready1 && !(in_valid1 && in_valid2))) lone_bad++;
         if (in_ready1 && first_load < 0) first_load = tcyc;
         acc1 = in_ready1;
         acc2 = in_ready2;
         if (in_ready1) i1++;
         if (in_ready2) i2++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
   endtask

   // Reference: beats pair up in arrival order; each pair emits ch1 then ch2, closing on l1|l2.
   task automatic check_run(input string tag);
      logic [9:0]  ex[$];
      logic [31:0] obs;
      int          n, closes = 0, errs = 0;
      n = (s_d1.size() < s_d2.size()) ? s_d1.size() : s_d2.size();
      for (int p = 0; p < n; p++) begin
         ex.push_back({1'b0, 1'b0, s_d1[p]});
         ex.push_back({s_l1[p] | s_l2[p], 1'b1, s_d2[p]});
         if (s_l1[p] | s_l2[p]) closes++;
         if (s_l1[p] != s_l2[p]) errs++;
      end
      check({tag, ".timeout"}, {31'd0, timed_out}, 32'd0);
      check({tag, ".beats"}, got_q.size(), ex.size());
      for (int i = 0; i < ex.size(); i++) begin
         obs = (i < got_q.size()) ? {22'd0, got_q[i]} : 32'hffff_ffff;
         check($sformatf("%s.beat%0d", tag, i), obs, {22'd0, ex[i]});
      end
      check({tag, ".pkt_cnt"}, pkt_cnt, closes % (1 << CW));
      check({tag, ".err_cnt"}, err_cnt, (errs > (1 << CW) - 1) ? (1 << CW) - 1 : errs);
      check({tag, ".len_err_pulses"}, lenerr_n, errs);
      check({tag, ".stall_hold"}, stall_bad, 0);
      check({tag, ".lone_valid"}, lone_bad, 0);
   endtask

   task automatic aligned8();
      for (int i = 0; i < 8; i++) begin
         add1(8'(i), i == 7);
         add2(8'(8'h10 + i), i == 7);
      end
   endtask

   initial begin
      // 1: aligned length-8 packets, free-flowing output
      do_reset("s1.reset");
      clear_run(); aligned8();
      run_stream(); check_run("s1");

      // 2: output backpressure alternating 1,0,1,0
      do_reset("s2.reset");
      clear_run(); aligned8(); rdy_mode = 1;
      run_stream(); check_run("s2");

      // 3: ch2 arrives 6 cycles late
      do_reset("s3.reset");
      clear_run(); aligned8(); start2 = 6;
      run_stream(); check_run("s3");
      check("s3.first_load_delay", first_load - run_start, 6);
      check("s3.latency", first_out - first_load, 1);

      // 4: last markers disagree (ch1 len 4, ch2 len 5); ch2's 5th beat is never paired
      do_reset("s4.reset");
      clear_run();
      for (int i = 0; i < 4; i++) add1(8'(8'h40 + i), i == 3);
      for (int i = 0; i < 5; i++) add2(8'(8'h50 + i), i == 4);
      run_stream(); check_run("s4");

      // 5: three back-to-back length-4 packets, no bubbles
      do_reset("s5.reset");
      clear_run();
      for (int i = 0; i < 12; i++) begin
         add1(8'(8'h20 + i), i % 4 == 3);
         add2(8'(8'h30 + i), i % 4 == 3);
      end
      run_stream(); check_run("s5");
      check("s5.span", last_hs - first_hs, 23);

      // 6: asynchronous reset while output beat 5 is on the bus
      do_reset("s6.reset");
      clear_run(); aligned8(); abort_at = 5;
      run_stream();
      check("s6.beats_before_rst", got_q.size(), 4);
      #2 rst = 1'b0;
      #1 check_idle("s6.async_rst");
      in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      check_idle("s6.held_rst");
      rst = 1'b1;
      @(posedge clk); #1;
      clear_run();
      for (int i = 0; i < 8; i++) begin
         add1(8'($urandom), i == 7);
         add2(8'($urandom), i == 7);
      end
      run_stream(); check_run("s6.fresh");

      // 7: error counter saturation and packet counter wrap
      do_reset("s7.reset");
      clear_run();
      for (int i = 0; i < 20; i++) begin
         add1(8'($urandom), 1'b1);
         add2(8'($urandom), 1'b0);
      end
      run_stream(); check_run("s7");

      // 8: random data, lasts, valid gaps and backpressure
      for (int r = 0; r < 3; r++) begin
         do_reset($sformatf("s8.%0d.reset", r));
         clear_run(); vmode = 1; rdy_mode = 2;
         for (int i = 0; i < 50; i++) begin
            add1(8'($urandom), $urandom_range(0, 2) == 0);
            add2(8'($urandom), $urandom_range(0, 2) == 0);
         end
         run_stream(); check_run($sformatf("s8.%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pack_interleave.md
Name: pack_interleave

Overview:
- Downstream consumer of the two-stream `sync` stage. It takes the two time-aligned packet streams (data/valid/last per channel) and merges them into one interleaved byte stream: ch1 beat, ch2 beat, ch1 beat, and so on.
- It handles backpressure, sustains back-to-back pairs at one output beat per clock, and counts packets.
- It flags packets whose `last` markers disagree between channels.

Parameters:
- DATA_W, 8, width of every data bus.
- CNT_W, 16, width of `pkt_cnt` and `err_cnt`.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data1  in  DATA_W  channel-1 beat.
- in_valid1  in  1  channel-1 beat present.
- in_last1  in  1  channel-1 final beat of packet.
- in_ready1  out  1  channel-1 beat accepted this cycle.
- in_data2  in  DATA_W  channel-2 beat.
- in_valid2  in  1  channel-2 beat present.
- in_last2  in  1  channel-2 final beat of packet.
- in_ready2  out  1  channel-2 beat accepted this cycle.
- out_data  out  DATA_W  interleaved beat.
- out_valid  out  1  out_data valid.
- out_last  out  1  final beat of the merged packet.
- out_src  out  1  0 = beat from ch1, 1 = beat from ch2.
- out_ready  in  1  downstream accepts the beat.
- len_err  out  1  one-cycle pulse on a last-marker mismatch.
- pkt_cnt  out  CNT_W  merged packets completed.
- err_cnt  out  CNT_W  mismatches seen.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: in_ready*, out_*, len_err, pkt_cnt, err_cnt.
  - Pair registers are cleared and any held data is discarded.
  - Reset asserted mid-packet drops the partial packet silently; no error is flagged.
- Pair register: holds d1, d2, l1, l2, written only on a load.
- load = in_valid1 & in_valid2 & (state==IDLE | (state==SEND2 & out_ready)).
- in_ready1 = in_ready2 = load (combinational).
  - Both channels are always accepted together; a lone valid is never consumed.
- FSM states:
  - IDLE: out_valid=0. On load → SEND1.
  - SEND1: out_valid=1, out_data=d1, out_src=0, out_last=0. On out_ready → SEND2; otherwise hold all outputs stable.
  - SEND2: out_valid=1, out_data=d2, out_src=1, out_last=l1|l2.
    - On out_ready & load → SEND1 with the new pair (no bubble).
    - On out_ready & !load → IDLE.
    - Without out_ready, hold.
- Output registers: out_* are registered. The first output beat appears the cycle after load, so latency is 1 clock.
- Throughput: 1 output beat per clock, i.e. one input pair per 2 clocks, when inputs are continuous and out_ready=1.
- Mismatch (l1 != l2 on a loaded pair):
  - len_err pulses for 1 cycle, the cycle after load.
  - err_cnt increments and saturates at all-ones.
  - The merged packet is force-closed: out_last=1 on that pair's SEND2 beat.
- pkt_cnt: increments on the handshake out_valid & out_ready & out_last; wraps modulo 2^CNT_W.
- out_ready low: held for any duration without loss or duplication; inputs are stalled because load=0.
- No combinational path from out_ready to out_data/out_valid; the only paths are into in_ready*.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'd0, SEND1=2'd1, SEND2=2'd2) and the default DATA_W/CNT_W constants.
- One sub-module is natural: pi_stat_cnt, the pkt/err counter pair with saturate/wrap select.
- The FSM and pair register stay in the top level.

Test Plan:
1. Length-8 packets on both channels, data 0..7 on ch1 and 8'h10..8'h17 on ch2, aligned, out_ready=1 → 16 beats 00,10,01,11,…,07,17; out_src toggles 0,1,…; out_last only on beat 16; pkt_cnt=1; err_cnt=0.
2. Same packets with out_ready toggled 1,0,1,0 → identical 16-beat sequence, no duplicate or missing beat, out_data stable while stalled, in_ready low during stalls.
3. ch2 valid arrives 6 cycles after ch1 → in_ready1 stays 0 for those 6 cycles, the first output beat is 1 clock after both are valid, and the byte order matches scenario 1.
4. ch1 last on beat 4, ch2 last on beat 5 → len_err pulses once after the 4th pair loads, out_last on output beat 8, err_cnt=1, pkt_cnt=1.
5. Three back-to-back length-4 packets, continuous valids, out_ready=1 → 24 output beats in 24 consecutive cycles, no bubble, pkt_cnt=3.
6. rst pulled low at output beat 5 of a length-8 packet → all outputs 0 immediately; after release a fresh packet emerges correctly with pkt_cnt counting from 0.
